// File: rtl/booth_controller_if.sv
// Control/status bundle between the Booth sequencer, its datapath and the host.
// The slave view belongs to the sequencer. The master view is the datapath/host side.
`timescale 1ns/1ps
interface booth_controller_if;
    logic       start;
    logic [1:0] Y0Yminus1;
    logic       ready;
    logic       done;
    logic       ldX;
    logic       ldY;
    logic       initA;
    logic       initYminusOne;
    logic       ldA;
    logic       aBarS;
    logic       shRA;
    logic       shRY;
    logic       ldYminusOne;
    logic       selL;
    logic       selR;

    modport slave (
        input  start, Y0Yminus1,
        output ready, done, ldX, ldY, initA, initYminusOne,
               ldA, aBarS, shRA, shRY, ldYminusOne, selL, selR
    );

    modport master (
        output start, Y0Yminus1,
        input  ready, done, ldX, ldY, initA, initYminusOne,
               ldA, aBarS, shRA, shRY, ldYminusOne, selL, selR
    );
endinterface

// File: rtl/booth_controller.sv
// Sequencer for a radix-2 Booth multiplier: load X and Y, run WIDTH add/sub+shift
// iterations, then present the product high half first and low half second.
`timescale 1ns/1ps
module booth_controller #(
    parameter int WIDTH = 6,
    parameter int CNT_W = 3
) (
    input  logic               clk,
    input  logic               rst,
    booth_controller_if.slave  bus
);
    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_X,
        S_LOAD_Y,
        S_CHECK,
        S_SHIFT,
        S_OUT_HI,
        S_OUT_LO
    } state_t;

    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // State-only outputs are registered from the next state, so they line up
    // cycle-for-cycle with a decode of the current state.
    logic ready_q,  ready_d;
    logic ld_x_q,   ld_x_d;
    logic ld_y_q,   ld_y_d;
    logic check_q,  check_d;
    logic shift_q,  shift_d;
    logic out_hi_q, out_hi_d;
    logic out_lo_q, out_lo_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            S_IDLE:   if (bus.start) state_d = S_LOAD_X;
            S_LOAD_X: state_d = S_LOAD_Y;
            S_LOAD_Y: begin
                cnt_d   = '0;
                state_d = S_CHECK;
            end
            S_CHECK:  state_d = S_SHIFT;
            S_SHIFT: begin
                if (cnt_q == LAST_ITER) begin
                    state_d = S_OUT_HI;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_CHECK;
                end
            end
            S_OUT_HI: state_d = S_OUT_LO;
            S_OUT_LO: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase
    end

    always_comb begin
        ready_d  = (state_d == S_IDLE);
        ld_x_d   = (state_d == S_LOAD_X);
        ld_y_d   = (state_d == S_LOAD_Y);
        check_d  = (state_d == S_CHECK);
        shift_d  = (state_d == S_SHIFT);
        out_hi_d = (state_d == S_OUT_HI);
        out_lo_d = (state_d == S_OUT_LO);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ready_q  <= 1'b1;
            ld_x_q   <= 1'b0;
            ld_y_q   <= 1'b0;
            check_q  <= 1'b0;
            shift_q  <= 1'b0;
            out_hi_q <= 1'b0;
            out_lo_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
            ld_x_q   <= ld_x_d;
            ld_y_q   <= ld_y_d;
            check_q  <= check_d;
            shift_q  <= shift_d;
            out_hi_q <= out_hi_d;
            out_lo_q <= out_lo_d;
        end
    end

    // Booth recoding: 10 subtracts X, 01 adds X, 00/11 leave A alone.
    assign bus.ldA           = check_q & (bus.Y0Yminus1[1] ^ bus.Y0Yminus1[0]);
    assign bus.aBarS         = check_q & bus.Y0Yminus1[1] & ~bus.Y0Yminus1[0];

    assign bus.ready         = ready_q;
    assign bus.ldX           = ld_x_q;
    assign bus.ldY           = ld_y_q;
    assign bus.initA         = ld_y_q;
    assign bus.initYminusOne = ld_y_q;
    assign bus.shRA          = shift_q;
    assign bus.shRY          = shift_q;
    assign bus.ldYminusOne   = shift_q;
    assign bus.selL          = out_hi_q;
    assign bus.selR          = out_lo_q;
    assign bus.done          = out_lo_q;
endmodule

// File: tb/tb_booth_controller.sv
// Bench for booth_controller: a behavioural Booth datapath closes the loop, and
// products are compared against plain signed multiplication.
`timescale 1ns/1ps
module tb_booth_controller;
    localparam int WIDTH = 6;
    localparam int MAXK  = 2 * WIDTH + 6;
    localparam logic [12:0] IDLE_VEC = 13'h1000;
    localparam logic [12:0] LDX_VEC  = 13'h0400;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    booth_controller_if bus ();

    booth_controller #(.WIDTH(WIDTH), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Datapath model; A carries one guard bit so -32 * -32 does not overflow.
    logic [5:0] x_op = '0, y_op = '0;
    logic [5:0] x_reg = '0, y_reg = '0;
    logic [6:0] a_reg = '0;
    logic       ym1_reg = 1'b0;
    logic [5:0] in_bus, out_bus;

    assign in_bus        = bus.ldX ? x_op : y_op;
    assign bus.Y0Yminus1 = {y_reg[0], ym1_reg};
    assign out_bus       = bus.selL ? a_reg[5:0] : (bus.selR ? y_reg : 6'h00);

    always @(posedge clk) begin
        if (bus.ldX) x_reg <= in_bus;
        if (bus.ldY) y_reg <= in_bus;
        if (bus.initA) a_reg <= '0;
        if (bus.initYminusOne) ym1_reg <= 1'b0;
        if (bus.ldA) a_reg <= bus.aBarS ? a_reg - {x_reg[5], x_reg} : a_reg + {x_reg[5], x_reg};
        if (bus.shRA) a_reg <= {a_reg[6], a_reg[6:1]};
        if (bus.shRY) y_reg <= {a_reg[0], y_reg[5:1]};
        if (bus.ldYminusOne) ym1_reg <= y_reg[0];
    end

    // {ready, done, ldX, ldY, initA, initYm1, ldA, aBarS, shRA, shRY, ldYm1, selL, selR}
    logic [12:0] ctrl_now;
    assign ctrl_now = {bus.ready, bus.done, bus.ldX, bus.ldY, bus.initA, bus.initYminusOne,
                       bus.ldA, bus.aBarS, bus.shRA, bus.shRY, bus.ldYminusOne,
                       bus.selL, bus.selR};

    logic [12:0] obs_ctrl [0:MAXK];
    logic [1:0]  obs_pair [0:MAXK];

    // Expected controls in cycle k after start is sampled at edge 0.
    function automatic logic [12:0] exp_ctrl(input int k, input logic [1:0] pair);
        logic [12:0] v;
        v = '0;
        if (k <= 0 || k >= 2 * WIDTH + 5) v[12] = 1'b1;
        else if (k == 1) v[10] = 1'b1;
        else if (k == 2) v[9:7] = 3'b111;
        else if (k <= 2 * WIDTH + 2) begin
            if ((k - 3) % 2 == 0) begin
                v[6] = (pair == 2'b10) || (pair == 2'b01);
                v[5] = (pair == 2'b10);
            end else begin
                v[4:2] = 3'b111;
            end
        end else if (k == 2 * WIDTH + 3) v[1] = 1'b1;
        else begin
            v[11] = 1'b1;
            v[0]  = 1'b1;
        end
        return v;
    endfunction

    // Runs one multiply and records what it sees; comparisons live in the tests.
    task automatic run_mult(input logic [5:0] x, input logic [5:0] y, input int pulse_k,
                            input bit hold, input int rst_k,
                            output logic [5:0] hi, output logic [5:0] lo,
                            output int done_k, output bit started);
        x_op = x;
        y_op = y;
        hi = '0;
        lo = '0;
        done_k = -1;
        started = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.ready) begin
                started = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
        if (started) begin
            obs_ctrl[0] = ctrl_now;
            obs_pair[0] = bus.Y0Yminus1;
            bus.start = 1'b1;
            @(posedge clk); #1;
            for (int k = 1; k <= MAXK; k++) begin
                obs_ctrl[k] = ctrl_now;
                obs_pair[k] = bus.Y0Yminus1;
                if (bus.selL) hi = out_bus;
                if (bus.selR) lo = out_bus;
                if (bus.done && done_k < 0) done_k = k;
                bus.start = hold || (k == pulse_k);
                if (k == rst_k) rst = 1'b1;
                else rst = 1'b0;
                @(posedge clk); #1;
            end
            bus.start = 1'b0;
            rst = 1'b0;
        end
    endtask

    task automatic test_reset();
        bus.start = 1'b0;
        rst = 1'b1;
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        checks++;
        if (ctrl_now !== IDLE_VEC) begin
            errors++;
            $display("FAIL reset_outputs: got %h want %h", ctrl_now, IDLE_VEC);
        end
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            checks++;
            if (ctrl_now !== IDLE_VEC) begin
                errors++;
                $display("FAIL idle_hold cycle %0d: got %h want %h", i, ctrl_now, IDLE_VEC);
            end
        end
        $display("test_reset: reset + 10 idle cycles observed");
    endtask

    task automatic test_directed(input string name, input logic [5:0] x, input logic [5:0] y,
                                 input logic [5:0] want_hi, input logic [5:0] want_lo);
        logic [5:0] hi, lo;
        int done_k;
        bit started;
        run_mult(x, y, -1, 1'b0, -1, hi, lo, done_k, started);
        checks++;
        if (!started || hi !== want_hi || lo !== want_lo || done_k != 16) begin
            errors++;
            $display("FAIL %s: got hi=%b lo=%b done@%0d started=%0b want hi=%b lo=%b done@16",
                     name, hi, lo, done_k, started, want_hi, want_lo);
        end
        for (int k = 0; k <= MAXK; k++) begin
            checks++;
            if (obs_ctrl[k] !== exp_ctrl(k, obs_pair[k])) begin
                errors++;
                $display("FAIL %s_ctrl cycle %0d: got %h want %h", name, k, obs_ctrl[k],
                         exp_ctrl(k, obs_pair[k]));
            end
        end
        $display("%s: X=%b Y=%b -> hi=%b lo=%b done@%0d", name, x, y, hi, lo, done_k);
    endtask

    task automatic test_positive();
        test_directed("positive", 6'd3, 6'd5, 6'b000000, 6'b001111);
        checks++;
        if (obs_pair[3] !== 2'b10 || obs_ctrl[3][6:5] !== 2'b11) begin
            errors++;
            $display("FAIL first_check: got pair=%b ldA/aBarS=%b want pair=10 ldA/aBarS=11",
                     obs_pair[3], obs_ctrl[3][6:5]);
        end
    endtask

    task automatic test_busy_start();
        logic [5:0] hi, lo;
        int done_k, ldx_cnt;
        bit started;
        run_mult(6'd3, 6'd5, 5, 1'b0, -1, hi, lo, done_k, started);
        ldx_cnt = 0;
        for (int k = 0; k <= MAXK; k++) if (obs_ctrl[k][10]) ldx_cnt++;
        checks++;
        if (!started || hi !== 6'd0 || lo !== 6'd15 || done_k != 16 || ldx_cnt != 1) begin
            errors++;
            $display("FAIL busy_start: got hi=%0d lo=%0d done@%0d ldX=%0d want 0 15 16 1",
                     hi, lo, done_k, ldx_cnt);
        end
        for (int k = 0; k <= MAXK; k++) begin
            checks++;
            if (obs_ctrl[k] !== exp_ctrl(k, obs_pair[k])) begin
                errors++;
                $display("FAIL busy_ctrl cycle %0d: got %h want %h", k, obs_ctrl[k],
                         exp_ctrl(k, obs_pair[k]));
            end
        end
        $display("test_busy_start: lo=%0d done@%0d ldX pulses=%0d", lo, done_k, ldx_cnt);
    endtask

    task automatic test_reset_mid();
        logic [5:0] hi, lo;
        int done_k;
        bit started;
        // The third SHIFT is cycle 8; reset sampled at edge 9.
        run_mult(6'd3, 6'd5, -1, 1'b0, 8, hi, lo, done_k, started);
        checks++;
        if (!started || obs_ctrl[8][4:2] !== 3'b111 || obs_ctrl[9] !== IDLE_VEC || done_k != -1) begin
            errors++;
            $display("FAIL reset_mid: got c8=%h c9=%h done@%0d want shift then %h, no done",
                     obs_ctrl[8], obs_ctrl[9], done_k, IDLE_VEC);
        end
        $display("test_reset_mid: cycle9 ctrl=%h", obs_ctrl[9]);
        test_directed("after_reset", 6'd3, 6'd5, 6'd0, 6'd15);
    endtask

    task automatic test_back_to_back();
        logic [5:0] hi, lo;
        int done_k, wait_cycles;
        bit started;
        run_mult(6'd3, 6'd5, -1, 1'b1, -1, hi, lo, done_k, started);
        checks++;
        if (!started || lo !== 6'd15 || done_k != 16 || obs_ctrl[17] !== IDLE_VEC
            || obs_ctrl[18] !== LDX_VEC) begin
            errors++;
            $display("FAIL back_to_back: got lo=%0d done@%0d c17=%h c18=%h want 15 16 %h %h",
                     lo, done_k, obs_ctrl[17], obs_ctrl[18], IDLE_VEC, LDX_VEC);
        end
        wait_cycles = 0;
        while (!bus.ready && wait_cycles < 40) begin
            @(posedge clk); #1;
            wait_cycles++;
        end
        checks++;
        if (!bus.ready) begin
            errors++;
            $display("FAIL back_to_back_ready: got ready=%b after %0d cycles want 1", bus.ready,
                     wait_cycles);
        end
        $display("test_back_to_back: second op started at cycle 18, idle after %0d more", wait_cycles);
    endtask

    task automatic test_random();
        logic [5:0] x, y, hi, lo;
        logic [11:0] want;
        int p, done_k;
        bit started;
        for (int n = 0; n < 24; n++) begin
            x = 6'($urandom);
            y = 6'($urandom);
            p = int'($signed(x)) * int'($signed(y));
            want = 12'(p);
            run_mult(x, y, -1, 1'b0, -1, hi, lo, done_k, started);
            checks++;
            if (!started || {hi, lo} !== want || done_k != 16) begin
                errors++;
                $display("FAIL random_%0d: X=%0d Y=%0d got %h done@%0d want %h done@16",
                         n, $signed(x), $signed(y), {hi, lo}, done_k, want);
            end
            for (int k = 0; k <= MAXK; k++) begin
                checks++;
                if (obs_ctrl[k] !== exp_ctrl(k, obs_pair[k]) || (obs_ctrl[k][1] && obs_ctrl[k][0])) begin
                    errors++;
                    $display("FAIL random_%0d_ctrl cycle %0d: got %h want %h", n, k, obs_ctrl[k],
                             exp_ctrl(k, obs_pair[k]));
                end
            end
            $display("random %0d: %0d * %0d = %0d (got %h)", n, $signed(x), $signed(y), p, {hi, lo});
        end
    endtask

    initial begin
        bus.start = 1'b0;
        test_reset();
        test_positive();
        test_directed("mixed", 6'b111101, 6'd2, 6'b111111, 6'b111010);
        test_directed("corner", 6'b100000, 6'b100000, 6'b010000, 6'b000000);
        test_busy_start();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
